// File: rtl/mul_share_arb.sv
// Round-robin sequencer sharing one pipelined fixed-point multiplier among NREQ requesters.
// Optional macro MUL_ARB_PRIO0_EN gives requester 0 fixed priority over the round-robin group.
module mul_share_arb #(
    parameter int NREQ      = 4,
    parameter int MUL_WIDTH = 17,
    parameter int RES_WIDTH = 32,
    parameter int MUL_LAT   = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*MUL_WIDTH-1:0] req_a,
    input  logic [NREQ*MUL_WIDTH-1:0] req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic [MUL_WIDTH-1:0]      mul_a,
    output logic [MUL_WIDTH-1:0]      mul_b,
    output logic                      mul_start,
    input  logic [RES_WIDTH-1:0]      mul_data,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [RES_WIDTH-1:0]      rsp_data,
    output logic                      busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef struct packed {
        logic          vld;
        logic [IW-1:0] idx;
    } tag_t;

    state_t              state, state_nx;
    logic [IW-1:0]       ptr, gnt_idx, cand;
    logic                found, xfer, clr, pipe_live;
    logic [NREQ-1:0]     rr_valid;
    tag_t                new_tag;
    tag_t [MUL_LAT:0]    tag_pipe;

    assign clr  = rst_n | flush;
    assign busy = (state != IDLE);

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
`ifdef MUL_ARB_PRIO0_EN
        rr_valid = req_valid & {{(NREQ-1){1'b1}}, 1'b0};
`else
        rr_valid = req_valid;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && rr_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
`ifdef MUL_ARB_PRIO0_EN
        if (req_valid[0]) begin
            found   = 1'b1;
            gnt_idx = '0;
        end
`endif
    end

    // Grant is suppressed in the reset/flush cycle so nothing is accepted and then lost.
    assign xfer = found & ~clr;

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        new_tag.vld = xfer;
        new_tag.idx = gnt_idx;
    end

    // Entries that will still be in the pipe after this cycle's shift.
    always_comb begin
        pipe_live = 1'b0;
        for (int k = 0; k < MUL_LAT; k++) pipe_live = pipe_live | tag_pipe[k].vld;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (xfer) state_nx = RUN;
            RUN:     if (!xfer) state_nx = DRAIN;
            DRAIN: begin
                if (xfer)            state_nx = RUN;
                else if (!pipe_live) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            ptr       <= IW'(NREQ - 1);
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            tag_pipe  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nx;
            mul_start <= (state_nx != IDLE);
            mul_a     <= xfer ? req_a[gnt_idx*MUL_WIDTH +: MUL_WIDTH] : '0;
            mul_b     <= xfer ? req_b[gnt_idx*MUL_WIDTH +: MUL_WIDTH] : '0;
            // Pipe is empty whenever mul_start is low, so shifting on the first issue is harmless.
            if (mul_start || xfer) tag_pipe <= {tag_pipe[MUL_LAT-1:0], new_tag};
            rsp_valid <= '0;
            if (tag_pipe[MUL_LAT].vld) begin
                rsp_valid[tag_pipe[MUL_LAT].idx] <= 1'b1;
                rsp_data                         <= mul_data;
            end
`ifdef MUL_ARB_PRIO0_EN
            if (xfer && gnt_idx != '0) ptr <= gnt_idx;
`else
            if (xfer) ptr <= gnt_idx;
`endif
        end
    end
endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb with a behavioural start-gated Q16 multiplier.
module tb_mul_share_arb;
    localparam int NREQ = 4;
    localparam int MW   = 17;
    localparam int RW   = 32;
    localparam int LAT  = 10;

    localparam logic [16:0] TBL [8] = '{17'h02000, 17'h04000, 17'h06000, 17'h08000,
                                        17'h0A000, 17'h0C000, 17'h1E000, 17'h10000};
    localparam logic [31:0] PRD [8] = '{32'h00001000, 32'h00002000, 32'h00003000, 32'h00004000,
                                        32'h00005000, 32'h00006000, 32'hFFFFF000, 32'hFFFF8000};

    logic                 clk = 1'b0;
    logic                 rst_n, flush;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*MW-1:0]   req_a, req_b;
    logic [NREQ-1:0]      req_ready;
    logic [MW-1:0]        mul_a, mul_b;
    logic                 mul_start;
    logic [RW-1:0]        mul_data;
    logic [NREQ-1:0]      rsp_valid;
    logic [RW-1:0]        rsp_data;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_share_arb dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_data(mul_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    function automatic logic [31:0] fmul(input logic [16:0] a, input logic [16:0] b);
        logic signed [33:0] p;
        p = $signed(a) * $signed(b);
        return 32'(p >>> 16);
    endfunction

    // Multiplier stand-in: advances only while start is high.
    logic [RW-1:0] mpipe [LAT];
    always @(posedge clk) begin
        if (mul_start) begin
            mpipe[0] <= fmul(mul_a, mul_b);
            for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
        end
    end
    assign mul_data = mpipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_in();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
    endtask

    task automatic drive(input int i, input logic [16:0] a, input logic [16:0] b);
        req_valid[i]     = 1'b1;
        req_a[i*MW +: MW] = a;
        req_b[i*MW +: MW] = b;
    endtask

    task automatic do_reset();
        step(); rst_n = 1'b1; idle_in();
        step(); rst_n = 1'b0;
    endtask

    task automatic wait_quiet(input int n);
        for (int i = 0; i < n; i++) begin
            step(); #1;
            chk("quiet_rsp", 32'(rsp_valid), 32'(0));
        end
    endtask

    task automatic flush_test(input bit use_rst);
        do_reset();
        for (int c = 0; c < 5; c++) begin
            step(); idle_in();
            for (int i = 0; i < NREQ; i++) drive(i, 17'h08000, 17'h08000);
            #1;
            chk("fl_issue_rdy", 32'(req_ready), 32'(1 << (c % 4)));
        end
        step(); idle_in();
        wait_quiet(2);
        step();
        if (use_rst) rst_n = 1'b1; else flush = 1'b1;
        drive(3, 17'h08000, 17'h08000);
        #1;
        chk("fl_cycle_rdy", 32'(req_ready), 32'(0));
        chk("fl_cycle_start", 32'(mul_start), 32'(1));
        step(); rst_n = 1'b0; flush = 1'b0; idle_in(); #1;
        chk("fl_after_start", 32'(mul_start), 32'(0));
        chk("fl_after_busy", 32'(busy), 32'(0));
        chk("fl_after_rdy", 32'(req_ready), 32'(0));
        chk("fl_after_mula", 32'(mul_a), 32'(0));
        chk("fl_after_rsp", 32'(rsp_valid), 32'(0));
        wait_quiet(15);
        step(); drive(2, 17'h08000, 17'h1C000); #1;
        chk("fl_new_rdy", 32'(req_ready), 32'(4'b0100));
        step(); idle_in(); #1;
        chk("fl_new_start", 32'(mul_start), 32'(1));
        wait_quiet(10);
        step(); #1;
        chk("fl_new_rsp", 32'(rsp_valid), 32'(4'b0100));
        chk("fl_new_data", rsp_data, 32'hFFFFE000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; flush = 1'b0; idle_in();
        step(); step();
        drive(0, 17'h08000, 17'h08000); #1;
        chk("rst_rdy", 32'(req_ready), 32'(0));
        chk("rst_start", 32'(mul_start), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rsp", 32'(rsp_valid), 32'(0));
        chk("rst_data", rsp_data, 32'(0));
        chk("rst_mula", 32'(mul_a), 32'(0));
        step(); rst_n = 1'b0; idle_in();

        // single op
        step(); drive(0, 17'h08000, 17'h08000); #1;
        chk("one_rdy", 32'(req_ready), 32'(4'b0001));
        step(); idle_in(); #1;
        chk("one_start", 32'(mul_start), 32'(1));
        chk("one_mula", 32'(mul_a), 32'h08000);
        chk("one_mulb", 32'(mul_b), 32'h08000);
        chk("one_busy", 32'(busy), 32'(1));
        wait_quiet(10);
        step(); #1;
        chk("one_rsp", 32'(rsp_valid), 32'(4'b0001));
        chk("one_data", rsp_data, 32'h00004000);
        chk("one_busy_end", 32'(busy), 32'(0));
        chk("one_start_end", 32'(mul_start), 32'(0));
        step(); #1;
        chk("one_rsp_pulse", 32'(rsp_valid), 32'(0));
        chk("one_data_hold", rsp_data, 32'h00004000);

        // negative product
        step(); drive(1, 17'h1C000, 17'h08000); #1;
        chk("neg_rdy", 32'(req_ready), 32'(4'b0010));
        step(); idle_in(); #1;
        chk("neg_mula", 32'(mul_a), 32'h1C000);
        wait_quiet(10);
        step(); #1;
        chk("neg_rsp", 32'(rsp_valid), 32'(4'b0010));
        chk("neg_data", rsp_data, 32'hFFFFE000);

        // contention: all four valid for 8 cycles
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step(); idle_in();
            for (int i = 0; i < NREQ; i++) drive(i, TBL[c], 17'h08000);
            #1;
            chk("ct_rdy", 32'(req_ready), 32'(1 << (c % 4)));
            if (c > 0) chk("ct_mula", 32'(mul_a), 32'(TBL[c-1]));
        end
        step(); idle_in(); #1;
        chk("ct_mula_last", 32'(mul_a), 32'(TBL[7]));
        wait_quiet(3);
        for (int c = 0; c < 8; c++) begin
            step(); #1;
            chk("ct_rsp", 32'(rsp_valid), 32'(1 << (c % 4)));
            chk("ct_data", rsp_data, PRD[c]);
        end
        step(); #1;
        chk("ct_rsp_end", 32'(rsp_valid), 32'(0));
        chk("ct_busy_end", 32'(busy), 32'(0));

        // gap: issue, 3 idle cycles, issue again
        step(); drive(0, 17'h04000, 17'h04000); #1;
        chk("gap_rdy0", 32'(req_ready), 32'(4'b0001));
        for (int t = 1; t <= 17; t++) begin
            int er;
            step(); idle_in();
            if (t == 4) drive(1, 17'h1C000, 17'h04000);
            #1;
            if (t == 4) chk("gap_rdy1", 32'(req_ready), 32'(4'b0010));
            chk("gap_start", 32'(mul_start), (t <= 15) ? 32'(1) : 32'(0));
            if (t == 1) chk("gap_mula0", 32'(mul_a), 32'h04000);
            if (t >= 2 && t <= 4) begin
                chk("gap_bub_a", 32'(mul_a), 32'(0));
                chk("gap_bub_b", 32'(mul_b), 32'(0));
            end
            if (t == 5) chk("gap_mula1", 32'(mul_a), 32'h1C000);
            er = (t == 12) ? 1 : (t == 16) ? 2 : 0;
            chk("gap_rsp", 32'(rsp_valid), 32'(er));
            if (t == 12) chk("gap_data0", rsp_data, 32'h00001000);
            if (t == 16) chk("gap_data1", rsp_data, 32'hFFFFF000);
        end

        flush_test(1'b0);
        flush_test(1'b1);

        // fixed-priority option vs plain round-robin
        do_reset();
        for (int c = 0; c < 4; c++) begin
            int er;
            step(); idle_in();
            drive(0, 17'h02000, 17'h02000);
            drive(2, 17'h02000, 17'h02000);
            #1;
`ifdef MUL_ARB_PRIO0_EN
            er = 1;
`else
            er = (c % 2 == 0) ? 1 : 4;
`endif
            chk("prio_rdy", 32'(req_ready), 32'(er));
        end
        step(); idle_in();
        for (int i = 0; i < 14; i++) step();
        #1;
        chk("prio_busy_end", 32'(busy), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Round-robin arbiter/sequencer that shares one pipelined 17-bit fixed-point multiplier (mul_five) among NREQ requesters in the SVM kernel datapath.
- Accepts operand pairs, drives the multiplier's mul_a/mul_b/start inputs, and holds start high while products are in flight.
- Tracks each issued operation with a requester tag matched to the multiplier latency, then routes each product back to its requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MUL_WIDTH, 17, operand width (bit 16 is the sign).
- RES_WIDTH, 32, product width returned by the multiplier.
- MUL_LAT, 10, cycles from operands and start presented to the multiplier until its data_five output is valid (start held high throughout).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, ACTIVE-HIGH (1 = reset), sampled on rising clk.
- flush  in  1  synchronous abort: drops all in-flight operations.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  NREQ*MUL_WIDTH  packed operand A; requester i at [i*MUL_WIDTH +: MUL_WIDTH].
- req_b  in  NREQ*MUL_WIDTH  packed operand B, same packing.
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- mul_a  out  MUL_WIDTH  multiplier operand A (registered).
- mul_b  out  MUL_WIDTH  multiplier operand B (registered).
- mul_start  out  1  multiplier start/advance (registered).
- mul_data  in  RES_WIDTH  multiplier data_five output.
- rsp_valid  out  NREQ  one-hot, one-cycle product-valid pulse to the owning requester.
- rsp_data  out  RES_WIDTH  product, shared by all requesters.
- busy  out  1  high while the state is RUN or DRAIN.

Behaviour:
- Reset or flush: every output goes to 0. State goes to IDLE, the tag pipe clears, and the round-robin pointer resets to NREQ-1, so requester 0 wins first. req_ready is 0 during the reset/flush cycle. Products already in the multiplier are discarded and never signalled.
- Arbitration:
  - Grant goes to the first requester with valid set, searching from (ptr+1) mod NREQ upward with wrap.
  - req_ready is combinational from req_valid and ptr: at most one bit is set, and none when no requester is valid.
  - On a transfer, ptr becomes the granted index. With no transfer, ptr holds.
- Issue: on a transfer in cycle T, mul_a/mul_b take the granted operands at the end of T, and mul_start is 1 in T+1. In a cycle with mul_start=1 but no transfer, mul_a/mul_b are 0 (bubble).
- Tag pipe:
  - Shift register of depth MUL_LAT+1; each entry is {valid, idx}. It shifts every cycle mul_start=1 and holds when mul_start=0.
  - Issued operations insert {1, grant idx}; bubbles insert {0, x}.
- Response: when the exiting tag is valid, rsp_data <= mul_data and rsp_valid[idx] <= 1 (registered). Handshake-to-rsp_valid latency is exactly MUL_LAT+2 cycles (12 by default). rsp_valid is otherwise 0 and rsp_data holds its last value.
- Throughput: one issue per cycle, back-to-back, with no gaps across requesters.
- Outstanding: at most MUL_LAT+1 operations in flight; issue is never blocked by this. There is no response backpressure, so requesters must always accept rsp_valid.
- FSM:
  - IDLE (mul_start=0) -> RUN on the first transfer.
  - RUN (mul_start=1) -> DRAIN when a cycle ends with no transfer.
  - DRAIN (mul_start=1, bubbles) -> RUN on a transfer; -> IDLE when the tag pipe holds no valid entry after the shift.
  - Any state -> IDLE on rst_n or flush. rst_n dominates flush.
- Simultaneous transfer and final drain in one cycle: RUN wins.
- mul_start must never fall while a valid tag is in the pipe. The multiplier only advances under start, so this keeps latency constant.
- The controller performs no arithmetic on operands or products; the multiplier's sign/Q16 format passes through unchanged.

Optional Feature:
- MUL_ARB_PRIO0_EN defined: requester 0 has fixed priority; when req_valid[0] is set it is granted regardless of ptr, and ptr is not updated by requester-0 grants. Requesters 1..NREQ-1 stay round-robin among themselves.
- Undefined: pure round-robin over all NREQ requesters, as specified above.

Test Plan:
- Single op: reset, then req0 a=0x08000, b=0x08000 -> req_ready[0]=1; rsp_valid[0] 12 cycles later with rsp_data=0x00004000; busy returns to 0 after the drain.
- Negative: req1 a=0x1C000, b=0x08000 -> rsp_valid[1] with rsp_data=0xFFFFE000 after 12 cycles.
- Contention: all 4 valid for 8 cycles, distinct operands -> grants 0,1,2,3,0,1,2,3 back-to-back; responses arrive in the same order on 8 consecutive cycles, each with the correct product and one-hot owner.
- Gap/drain: issue, idle 3 cycles, issue again -> RUN->DRAIN->RUN with mul_start continuously 1, bubble operands 0, both responses at exactly 12 cycles.
- Flush mid-flight: 5 ops issued, flush asserted 4 cycles later -> no rsp_valid ever; mul_start=0 and req_ready=0 the next cycle; the next op after flush returns correctly after 12 cycles. Repeat using rst_n=1 instead of flush.
- MUL_ARB_PRIO0_EN defined: req0 and req2 valid continuously -> req0 granted every cycle. With it undefined -> grants alternate 0,2,0,2.
